// File: rtl/adder_walk_sequencer_pkg.sv
// Shared constants and state encoding for the adder walking-ones sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_walk_sequencer_pkg;

    localparam int DEF_ADDER_WIDTH = 32;
    localparam int DEF_NUM_VEC     = 7;
    localparam int DEF_INIT_CYCLES = 5;
    localparam int DEF_HOLD_CYCLES = 5;

    // first_fail_idx value meaning "no vector has failed yet"
    localparam logic [7:0] NO_FAIL_IDX = 8'hFF;
    // err_cnt sticks here instead of wrapping
    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/adder_vec_gen.sv
// Maps a vector index to walking-ones operands, carry-in and expected {cout,sum}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the index.
module adder_vec_gen #(
    parameter int ADDER_WIDTH = 32,
    parameter int IDX_W       = 6
) (
    input  logic [IDX_W-1:0]       i_idx,
    output logic [ADDER_WIDTH-1:0] o_in1,
    output logic [ADDER_WIDTH-1:0] o_in2,
    output logic                   o_cin,
    output logic [ADDER_WIDTH:0]   o_exp
);

    logic [ADDER_WIDTH-1:0] w_bit;

    // Both operands carry the same single one-hot bit; only vector 0 adds a carry-in,
    // so the top vector wraps to sum=0 with cout=1.
    always_comb begin
        w_bit = ADDER_WIDTH'(1) << i_idx;
        o_in1 = w_bit;
        o_in2 = w_bit;
        o_cin = (i_idx == '0);
        o_exp = {1'b0, w_bit} + {1'b0, w_bit} + {{ADDER_WIDTH{1'b0}}, o_cin};
    end

endmodule

// File: rtl/adder_walk_sequencer.sv
// Walks one-hot vectors through an external adder and counts {cout,sum} mismatches.
// Latency: done pulses INIT_CYCLES + NUM_VEC*HOLD_CYCLES + 1 cycles after start is accepted.
// Backpressure: none; start is only sampled in IDLE and is dropped while a run is active.
module adder_walk_sequencer
    import adder_walk_sequencer_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int NUM_VEC     = DEF_NUM_VEC,
    parameter int INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDER_WIDTH-1:0] sum,
    input  logic                   cout,
    output logic [ADDER_WIDTH-1:0] in1,
    output logic [ADDER_WIDTH-1:0] in2,
    output logic                   cin,
    output logic                   K,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             err_cnt,
    output logic [7:0]             first_fail_idx
);

    localparam int IDX_W = $clog2(ADDER_WIDTH + 1);
    // INIT_CYCLES and HOLD_CYCLES must stay below 2**CNT_W
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] VEC_LAST  = IDX_W'(NUM_VEC - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic                   w_accept;
    logic                   w_cmp;
    logic                   w_mismatch;

    logic [ADDER_WIDTH-1:0] w_gen_in1;
    logic [ADDER_WIDTH-1:0] w_gen_in2;
    logic                   w_gen_cin;
    logic [ADDER_WIDTH:0]   w_gen_exp;

    logic [ADDER_WIDTH-1:0] r_in1;
    logic [ADDER_WIDTH-1:0] r_in2;
    logic                   r_cin;
    logic                   r_k;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [7:0]             r_err;
    logic [7:0]             r_ffi;
    logic [ADDER_WIDTH:0]   r_exp;

    // Generator is fed the next index so the operand registers and the expected
    // value load in the same edge that the vector index changes.
    adder_vec_gen #(
        .ADDER_WIDTH (ADDER_WIDTH),
        .IDX_W       (IDX_W)
    ) u_vec_gen (
        .i_idx (w_idx_nxt),
        .o_in1 (w_gen_in1),
        .o_in2 (w_gen_in2),
        .o_cin (w_gen_cin),
        .o_exp (w_gen_exp)
    );

    // The compare uses the expected value captured alongside the operands in flight.
    assign w_mismatch = ({cout, sum} != r_exp);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, counters and the compare strobe on the last hold cycle of a vector
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        w_cmp       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                if (r_cnt == INIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_APPLY;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_APPLY: begin
                if (r_cnt == HOLD_LAST) begin
                    w_cmp     = 1'b1;
                    w_cnt_nxt = '0;
                    if (r_idx == VEC_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Hold-cycle and vector-index counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
        end
    end

    // Adder drive registers, decoded from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= 1'b1;
            r_busy <= 1'b0;
            r_in1  <= '0;
            r_in2  <= '0;
            r_cin  <= 1'b0;
            r_exp  <= '0;
        end else begin
            r_k    <= (w_state_nxt != ST_APPLY);
            r_busy <= (w_state_nxt == ST_INIT) || (w_state_nxt == ST_APPLY);
            r_exp  <= w_gen_exp;
            if (w_state_nxt == ST_APPLY) begin
                r_in1 <= w_gen_in1;
                r_in2 <= w_gen_in2;
                r_cin <= w_gen_cin;
            end else begin
                r_in1 <= '0;
                r_in2 <= '0;
                r_cin <= 1'b0;
            end
        end
    end

    // Run status: error tally, first failing index, and done/pass issued from the
    // DONE cycle so pass already reflects the final compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 8'd0;
            r_ffi  <= NO_FAIL_IDX;
        end else begin
            r_done <= (r_state == ST_DONE);
            if (w_accept) begin
                r_err  <= 8'd0;
                r_ffi  <= NO_FAIL_IDX;
                r_pass <= 1'b0;
            end else begin
                if (w_cmp && w_mismatch) begin
                    if (r_err != ERR_CNT_MAX) begin
                        r_err <= r_err + 8'd1;
                    end
                    if (r_ffi == NO_FAIL_IDX) begin
                        r_ffi <= 8'(r_idx);
                    end
                end
                if (r_state == ST_DONE) begin
                    r_pass <= (r_err == 8'd0);
                end
            end
        end
    end

    assign in1            = r_in1;
    assign in2            = r_in2;
    assign cin            = r_cin;
    assign K              = r_k;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err;
    assign first_fail_idx = r_ffi;

endmodule
